// File: rtl/dnn_drv_pkg.sv
// Shared types and constants for the DNNWeaver batch start/done driver.
package dnn_drv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } drv_state_t;

  localparam logic [1:0] CFG_NUM_RUNS = 2'd0;
  localparam logic [1:0] CFG_GAP      = 2'd1;
  localparam logic [1:0] CFG_TIMEOUT  = 2'd2;
  localparam logic [1:0] CFG_CLEAR    = 2'd3;

  localparam int DEF_CNT_W       = 64;
  localparam int DEF_RUN_W       = 16;
  localparam int DEF_GAP_W       = 16;
  localparam int DEF_START_PULSE = 1;

endpackage

// File: rtl/dnn_lat_stats.sv
// Per-run latency statistics: last, min, max and a total that saturates at all-ones.
module dnn_lat_stats
  import dnn_drv_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smp_vld,
  input  logic [CNT_W-1:0] smp_lat,
  output logic [CNT_W-1:0] last_cycles,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] total_cycles
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_cycles  <= '0;
      min_cycles   <= '1;
      max_cycles   <= '0;
      total_cycles <= '0;
    end else if (smp_vld) begin
      last_cycles  <= smp_lat;
      total_cycles <= sat_add(total_cycles, smp_lat);
      if (smp_lat < min_cycles) min_cycles <= smp_lat;
      if (smp_lat > max_cycles) max_cycles <= smp_lat;
    end
  end

endmodule

// File: rtl/dnn_bench_driver.sv
// Batch start/done driver for the accelerator: repeated runs with optional gap,
// per-run timeout and latency statistics. Requires CNT_W >= RUN_W and CNT_W >= GAP_W.
module dnn_bench_driver
  import dnn_drv_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RUN_W       = DEF_RUN_W,
  parameter int GAP_W       = DEF_GAP_W,
  parameter int START_PULSE = DEF_START_PULSE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             go,
  output logic             acc_start,
  input  logic             acc_done,
  output logic             busy,
  output logic             batch_done,
  output logic             timeout_err,
  output logic [RUN_W-1:0] run_idx,
  output logic [CNT_W-1:0] last_cycles,
  output logic [CNT_W-1:0] min_cycles,
  output logic [CNT_W-1:0] max_cycles,
  output logic [CNT_W-1:0] total_cycles
);

  localparam int PULSE_W = $clog2(START_PULSE + 1);

  drv_state_t       state;
  logic [RUN_W-1:0] num_runs;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] lat_nxt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic             is_idle;
  logic             cfg_clr;
  logic             smp_vld;
  logic             last_run;
  logic             to_hit;

  assign is_idle  = (state == ST_IDLE);
  assign lat_nxt  = lat_cnt + CNT_W'(1);
  assign cfg_clr  = is_idle && cfg_we && (cfg_addr == CFG_CLEAR);
  assign smp_vld  = (state == ST_WAIT) && acc_done;
  assign last_run = ((run_idx + RUN_W'(1)) == num_runs);
  assign to_hit   = (timeout != '0) && (lat_nxt == timeout);

  // Counters restart at each run start; reset only touches control and config state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc_start   <= 1'b0;
      busy        <= 1'b0;
      batch_done  <= 1'b0;
      timeout_err <= 1'b0;
      run_idx     <= '0;
      num_runs    <= RUN_W'(1);
      gap         <= '0;
      timeout     <= '0;
    end else begin
      if (is_idle && cfg_we) begin
        case (cfg_addr)
          CFG_NUM_RUNS: num_runs <= cfg_data[RUN_W-1:0];
          CFG_GAP:      gap      <= cfg_data[GAP_W-1:0];
          CFG_TIMEOUT:  timeout  <= cfg_data;
          default: begin
            run_idx     <= '0;
            timeout_err <= 1'b0;
          end
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            run_idx     <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (num_runs == '0) begin
              state      <= ST_FINISH;
              batch_done <= 1'b1;
            end else begin
              state     <= ST_START;
              acc_start <= 1'b1;
              lat_cnt   <= '0;
              pulse_cnt <= PULSE_W'(1);
            end
          end
        end
        ST_START: begin
          lat_cnt <= lat_nxt;
          if (pulse_cnt == PULSE_W'(START_PULSE)) begin
            acc_start <= 1'b0;
            state     <= ST_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PULSE_W'(1);
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_nxt;
          // A done on the timeout cycle still counts as a completed run.
          if (acc_done) begin
            run_idx <= run_idx + RUN_W'(1);
            if (last_run) begin
              state      <= ST_FINISH;
              batch_done <= 1'b1;
            end else if (gap == '0) begin
              state     <= ST_START;
              acc_start <= 1'b1;
              lat_cnt   <= '0;
              pulse_cnt <= PULSE_W'(1);
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_W'(1);
            end
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            state       <= ST_FINISH;
            batch_done  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap) begin
            state     <= ST_START;
            acc_start <= 1'b1;
            lat_cnt   <= '0;
            pulse_cnt <= PULSE_W'(1);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_FINISH: begin
          batch_done <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dnn_lat_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         ((is_idle && go) || cfg_clr),
    .smp_vld     (smp_vld),
    .smp_lat     (lat_nxt),
    .last_cycles (last_cycles),
    .min_cycles  (min_cycles),
    .max_cycles  (max_cycles),
    .total_cycles(total_cycles)
  );

endmodule

// File: doc/dnn_bench_driver.md
# dnn_bench_driver

Programmable batch driver for the DNNWeaver accelerator top. It issues a registered start pulse and waits for `acc_done`. It repeats this for a configured number of runs, with an optional idle gap between runs and a per-run timeout. It accumulates per-run latency statistics (last, min, max, saturating total) that host-side glue reads back. It sits between the host/soft-register glue and the accelerator's start/done pins, replacing the fixed single-shot start/wait driver.

## Interface
- `CNT_W`, 64: width of latency counters, statistics and timeout.
- `RUN_W`, 16: width of the run count and run index.
- `GAP_W`, 16: width of the inter-run gap counter.
- `START_PULSE`, 1: number of cycles `acc_start` is held high per run (≥1).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cfg_we`, in, 1: config write strobe.
- `cfg_addr`, in, 2: 0 = num_runs, 1 = gap, 2 = timeout, 3 = clear stats (data ignored).
- `cfg_data`, in, CNT_W: write data, LSB-aligned and truncated to the field width.
- `go`, in, 1: begin a batch.
- `acc_start`, out, 1: start to the accelerator (registered).
- `acc_done`, in, 1: done from the accelerator, level-sampled.
- `busy`, out, 1: high in every state except IDLE.
- `batch_done`, out, 1: one-cycle pulse at batch end.
- `timeout_err`, out, 1: sticky; set on timeout, cleared by `go` or clear stats.
- `run_idx`, out, RUN_W: completed runs in the current batch.
- `last_cycles`, `min_cycles`, `max_cycles`, `total_cycles`, out, CNT_W each: statistics.

## Operation
- **States:** IDLE, START, WAIT, GAP, FINISH.
- **Config registers:**
  - Writable only in IDLE; writes in other states are dropped.
  - Reset values: num_runs = 1, gap = 0, timeout = 0 (0 disables the timeout).
- **IDLE + `go`:**
  - run_idx ← 0, stats cleared, timeout_err ← 0.
  - num_runs == 0 → FINISH.
  - Otherwise → START.
  - `go` outside IDLE is ignored.
- **START:**
  - `acc_start` is high for exactly START_PULSE cycles, then → WAIT.
  - The latency counter is 0 in the first START cycle and increments every START/WAIT cycle.
  - `acc_done` is ignored in START.
- **WAIT, `acc_done` = 1:**
  - Latency L = lat_cnt + 1.
  - last ← L, min ← min(min, L), max ← max(max, L), total ← total + L, saturating at all-ones.
  - run_idx ← run_idx + 1.
  - If run_idx + 1 == num_runs → FINISH.
  - Else if gap == 0 → START.
  - Else → GAP.
- **WAIT, timeout:** timeout ≠ 0, no `acc_done`, and lat_cnt + 1 == timeout → timeout_err ← 1, stats unchanged, remaining runs aborted, → FINISH. If done and timeout occur in the same cycle, done wins.
- **GAP:** stays exactly `gap` cycles, then → START.
- **FINISH:** `batch_done` = 1 for one cycle, → IDLE.
- **Clear stats** (addr 3, IDLE only): last/max/total ← 0, min ← all-ones, run_idx ← 0, timeout_err ← 0.
- **Reset values:** all outputs 0, except `min_cycles` = all-ones. State = IDLE.

## Timing
- `go` sampled at edge t → `acc_start` high in cycles t+1 … t+START_PULSE.
- With START_PULSE = 1 and `acc_done` high in the first WAIT cycle: L = 2, and stats are visible the cycle after the done sample.
- `batch_done` is asserted the cycle after the final done sample. `busy` drops in the cycle after `batch_done`.
- Back-to-back runs with gap = 0: next `acc_start` is high in the cycle after the done sample.
- `rst` mid-run: at the next edge `acc_start`/`busy` go low and the state returns to IDLE. No `batch_done` is issued.
- All outputs are registered. No combinational path from `acc_done` or `go` to any output.

## Structure
- Package `dnn_drv_pkg`:
  - state enum.
  - cfg address constants (CFG_NUM_RUNS = 0, CFG_GAP = 1, CFG_TIMEOUT = 2, CFG_CLEAR = 3).
  - default parameter values.
- Sub-module `dnn_lat_stats`:
  - Inputs: sample valid, L, clear.
  - Holds last/min/max/saturating total.
  - Parameter CNT_W.
- The FSM, latency/gap/pulse counters and config registers stay in the top.

## Test plan
- **Basic:** num_runs = 1, gap = 0, START_PULSE = 1; `go`, done after 10 WAIT cycles → one 1-cycle `acc_start`, last = min = max = total = 11, run_idx = 1, single `batch_done`.
- **Multi-run:** num_runs = 3, gap = 4, latencies 5/9/7 → three starts, each 5 cycles after the preceding done; min = 5, max = 9, total = 21, run_idx = 3.
- **Timeout:** timeout = 20, `acc_done` never asserted → timeout_err = 1 at lat_cnt + 1 = 20, `batch_done` next cycle, run_idx = 0, min stays all-ones; a following `go` clears timeout_err.
- **Edge cases:**
  - num_runs = 0: `go` → no `acc_start`; `batch_done` the next cycle.
  - Done on the exact timeout cycle → counted as success, no timeout_err.
- **Illegal access:** cfg write and second `go` during WAIT → ignored (config readback unchanged, single batch); START_PULSE = 3 → `acc_start` high 3 cycles, done held high during START ignored.
- **Reset mid-WAIT:** `acc_start`/`busy` low, state IDLE, stats reset, no `batch_done`. Total saturation: forced near-max total plus L → all-ones.
